// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo counter: mode encoding and the parameter legality check.
package mod_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Parameters are legal when 1 <= width <= 32 and 2 <= modulus <= 2^width.
  function automatic bit params_ok(int width, longint unsigned modulus);
    if (width < 1 || width > 32) return 1'b0;
    if (modulus < 64'd2) return 1'b0;
    if (modulus > (64'd1 << width)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle of the modulo counter.
// Handshake: none. Controls are sampled on every rising clock edge; status is always valid.
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             tc;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up,
    input  count, at_max, at_min, tc, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output count, at_max, at_min, tc, ovf
  );
endinterface

// File: rtl/mod_counter_step.sv
// Combinational next-count and boundary-event logic for one counter channel.
module mod_counter_step
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_next,
  output logic [WIDTH-1:0] o_load_clamped,
  output logic             o_boundary,
  output logic             o_at_max,
  output logic             o_at_min
);

  // Range end held in WIDTH+1 bits so MODULUS = 2^WIDTH needs no special case.
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 64'd1);

  logic [WIDTH:0] w_cnt_ext;
  logic [WIDTH:0] w_lv_ext;
  logic           w_sat;

  assign w_cnt_ext = {1'b0, i_count};
  assign w_lv_ext  = {1'b0, i_load_val};
  assign w_sat     = (SATURATE == MODE_SAT);

  assign o_at_max       = (w_cnt_ext == MAX);
  assign o_at_min       = (i_count == '0);
  assign o_boundary     = i_up ? o_at_max : o_at_min;
  assign o_load_clamped = (w_lv_ext > MAX) ? MAX[WIDTH-1:0] : i_load_val;

  always_comb begin
    o_next = i_count;
    if (i_up) begin
      if (!o_at_max)  o_next = i_count + WIDTH'(1);
      else if (!w_sat) o_next = '0;
    end else begin
      if (!o_at_min)  o_next = i_count - WIDTH'(1);
      else if (!w_sat) o_next = MAX[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate mode, clear, load and wrap status.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              SATURATE = MODE_WRAP
) (
  input  logic          clk,
  input  logic          reset,
  mod_counter_if.slave  bus
);

  if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
    $error("mod_counter: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_boundary;
  logic             w_at_max;
  logic             w_at_min;

  mod_counter_step #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_step (
    .i_count        (r_count),
    .i_up           (bus.up),
    .i_load_val     (bus.load_val),
    .o_next         (w_next),
    .o_load_clamped (w_load_clamped),
    .o_boundary     (w_boundary),
    .o_at_max       (w_at_max),
    .o_at_min       (w_at_min)
  );

  // Priority clr > load > en; tc is a one-cycle echo of an enabled boundary step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.clr) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.load) begin
      r_count <= w_load_clamped;
      r_tc    <= 1'b0;
    end else if (bus.en) begin
      r_count <= w_next;
      r_tc    <= w_boundary;
      if (w_boundary) r_ovf <= 1'b1;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign bus.count  = r_count;
  assign bus.tc     = r_tc;
  assign bus.ovf    = r_ovf;
  assign bus.at_max = w_at_max;
  assign bus.at_min = w_at_min;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: wrap (M=10), saturate (M=10) and full-range (M=16) instances on shared stimulus.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1;
  logic [3:0] lv = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(4)) if_w ();
  mod_counter_if #(.WIDTH(4)) if_s ();
  mod_counter_if #(.WIDTH(4)) if_f ();

  assign if_w.clr = clr;  assign if_w.load = load;  assign if_w.load_val = lv;
  assign if_w.en  = en;   assign if_w.up   = up;
  assign if_s.clr = clr;  assign if_s.load = load;  assign if_s.load_val = lv;
  assign if_s.en  = en;   assign if_s.up   = up;
  assign if_f.clr = clr;  assign if_f.load = load;  assign if_f.load_val = lv;
  assign if_f.en  = en;   assign if_f.up   = up;

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (.clk(clk), .reset(reset), .bus(if_w.slave));
  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (.clk(clk), .reset(reset), .bus(if_s.slave));
  mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_f (.clk(clk), .reset(reset), .bus(if_f.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic c, input logic l, input logic e, input logic u, input logic [3:0] v);
    clr = c; load = l; en = e; up = u; lv = v;
  endtask

  task automatic chk_w(input string tag, input int c, input bit t, input bit o);
    chk({tag, ".count"},  32'(if_w.count), 32'(c));
    chk({tag, ".tc"},     32'(if_w.tc),    32'(t));
    chk({tag, ".ovf"},    32'(if_w.ovf),   32'(o));
    chk({tag, ".at_max"}, 32'(if_w.at_max), 32'(c == 9));
    chk({tag, ".at_min"}, 32'(if_w.at_min), 32'(c == 0));
  endtask

  // Reference model: count as plain integer arithmetic modulo MODULUS.
  int mods[3] = '{10, 10, 16};
  bit sats[3] = '{1'b0, 1'b1, 1'b0};
  int m_cnt[3];
  bit m_tc[3];
  bit m_ovf[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit bnd;
      if (clr) begin
        m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(lv) > mods[k] - 1) ? mods[k] - 1 : int'(lv);
        m_tc[k]  = 0;
      end else if (en) begin
        bnd = up ? (m_cnt[k] == mods[k] - 1) : (m_cnt[k] == 0);
        if (!(bnd && sats[k]))
          m_cnt[k] = (m_cnt[k] + (up ? 1 : mods[k] - 1)) % mods[k];
        m_tc[k] = bnd;
        if (bnd) m_ovf[k] = 1;
      end else begin
        m_tc[k] = 0;
      end
    end
  endtask

  task automatic chk_model(input string tag, input int k, input logic [3:0] c, input logic t,
                           input logic o, input logic amax, input logic amin);
    chk({tag, ".count"},  32'(c),    32'(m_cnt[k]));
    chk({tag, ".tc"},     32'(t),    32'(m_tc[k]));
    chk({tag, ".ovf"},    32'(o),    32'(m_ovf[k]));
    chk({tag, ".at_max"}, 32'(amax), 32'(m_cnt[k] == mods[k] - 1));
    chk({tag, ".at_min"}, 32'(amin), 32'(m_cnt[k] == 0));
  endtask

  typedef struct {
    logic       clr, load, en, up;
    logic [3:0] lv;
    int         exp_cnt;
    bit         exp_tc, exp_ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Directed vectors for the wrap instance, starting from reset.
    vecs[0] = '{0, 1, 0, 1, 4'd13, 9, 0, 0};
    vecs[1] = '{0, 0, 1, 1, 4'd0,  0, 1, 1};
    vecs[2] = '{0, 0, 1, 1, 4'd0,  1, 0, 1};
    vecs[3] = '{1, 1, 1, 1, 4'd5,  0, 0, 0};
    vecs[4] = '{0, 0, 1, 0, 4'd0,  9, 1, 1};
    vecs[5] = '{0, 0, 1, 0, 4'd0,  8, 0, 1};
    vecs[6] = '{0, 1, 1, 1, 4'd4,  4, 0, 1};
    vecs[7] = '{0, 0, 0, 1, 4'd0,  4, 0, 1};
    vecs[8] = '{0, 0, 1, 1, 4'd0,  5, 0, 1};
    vecs[9] = '{1, 0, 1, 1, 4'd0,  0, 0, 0};

    set_in(0, 0, 0, 1, 0);
    repeat (2) tick();
    chk_w("reset_w", 0, 0, 0);
    chk("reset_f.count", 32'(if_f.count), 32'd0);
    chk("reset_f.at_max", 32'(if_f.at_max), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
      tick();
      chk_w($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_tc, vecs[i].exp_ovf);
    end

    // Wrap up from 0 for 12 clocks.
    set_in(0, 0, 1, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_w($sformatf("wrap_up%0d", i), i % 10, i == 10, i >= 10);
    end

    // Asynchronous reset mid-count with ovf set.
    set_in(0, 1, 0, 1, 4'd7);
    tick();
    chk_w("load7", 7, 0, 1);
    set_in(0, 0, 0, 1, 0);
    #2 reset = 1'b1;
    #1 chk_w("async_reset", 0, 0, 0);
    tick();
    reset = 1'b0;

    // Wrap down from 0.
    set_in(0, 0, 1, 0, 0);
    tick();
    chk_w("wrap_dn0", 9, 1, 1);
    tick();
    chk_w("wrap_dn1", 8, 0, 1);

    // Saturate instance: up from 8 for 4 clocks, then reverse.
    set_in(1, 0, 0, 1, 0);
    tick();
    set_in(0, 1, 0, 1, 4'd8);
    tick();
    chk("sat_load.count", 32'(if_s.count), 32'd8);
    set_in(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sat%0d.count", i), 32'(if_s.count), 32'd9);
      chk($sformatf("sat%0d.tc", i),    32'(if_s.tc),    32'(i > 0));
      chk($sformatf("sat%0d.ovf", i),   32'(if_s.ovf),   32'(i > 0));
    end
    up = 1'b0;
    tick();
    chk("sat_rev.count", 32'(if_s.count), 32'd8);
    chk("sat_rev.tc",    32'(if_s.tc),    32'd0);

    // Full-range instance: 15 -> 0 up, 0 -> 15 down.
    set_in(0, 1, 0, 1, 4'd15);
    tick();
    chk("full_load.count", 32'(if_f.count), 32'd15);
    chk("full_load.at_max", 32'(if_f.at_max), 32'd1);
    set_in(0, 0, 1, 1, 0);
    tick();
    chk("full_up.count", 32'(if_f.count), 32'd0);
    chk("full_up.tc",    32'(if_f.tc),    32'd1);
    up = 1'b0;
    tick();
    chk("full_dn.count", 32'(if_f.count), 32'd15);
    chk("full_dn.tc",    32'(if_f.tc),    32'd1);
    en = 1'b0;
    tick();
    chk("full_idle.tc",  32'(if_f.tc),    32'd0);

    // Random traffic on all three instances against the model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 2) != 0);
      lv   = 4'($urandom_range(0, 15));
      tick();
      model_step();
      chk_model("rnd_w", 0, if_w.count, if_w.tc, if_w.ovf, if_w.at_max, if_w.at_min);
      chk_model("rnd_s", 1, if_s.count, if_s.tc, if_s.ovf, if_s.at_max, if_s.at_min);
      chk_model("rnd_f", 2, if_f.count, if_f.tc, if_f.ovf, if_f.at_max, if_f.at_min);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
